// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one start/done signed multiplier between NREQ requesters.
// One op in flight: grant+start 1 cycle, wait for done (watchdog), then hold the response until rsp_ready.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 15,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   a_in,
  input  logic [NREQ*W-1:0]   b_in,
  output logic [NREQ-1:0]     gnt,
  output logic                mul_strt,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  input  logic [2*W-1:0]      mul_p,
  input  logic                mul_done,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_p,
  output logic                rsp_err,
  input  logic                rsp_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   wait_cnt;
  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic            load_op, clr_cnt, inc_cnt, cap_done, cap_to;

  // Walk downward so the last hit is the nearest requester after the pointer.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        win_vld = 1'b1;
        win_id  = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_op   = 1'b0;
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
    cap_done  = 1'b0;
    cap_to    = 1'b0;
    gnt       = '0;
    mul_strt  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          load_op   = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        gnt[rsp_id] = 1'b1;
        mul_strt    = 1'b1;
        clr_cnt     = 1'b1;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over an expiring watchdog on the same edge
        if (mul_done) begin
          cap_done  = 1'b1;
          state_nxt = ST_RESP;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          cap_to    = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr      <= IDW'(NREQ - 1);
      mul_a    <= '0;
      mul_b    <= '0;
      rsp_id   <= '0;
      rsp_p    <= '0;
      rsp_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (load_op) begin
        ptr    <= win_id;
        rsp_id <= win_id;
        mul_a  <= a_in[win_id*W +: W];
        mul_b  <= b_in[win_id*W +: W];
      end
      if (clr_cnt) begin
        wait_cnt <= '0;
      end else if (inc_cnt) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (cap_done) begin
        rsp_p   <= mul_p;
        rsp_err <= 1'b0;
      end else if (cap_to) begin
        rsp_p   <= '0;
        rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential signed multiplier engine (start/done handshake, 4-bit two's-complement operands, 8-bit product) between NREQ requesters.
- Grants one requester at a time and captures its operands.
- Drives the engine's start pulse and waits for done, with a watchdog.
- Returns the product, tagged with the requester id, over a valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ) is a derived localparam.
- W, 4, operand width; product width is 2W.
- TIMEOUT, 15, maximum WAIT cycles allowed for mul_done before an error response is issued.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level; the requester holds it until it sees its gnt bit.
- a_in  input  NREQ*W  packed operand A; slice i belongs to requester i.
- b_in  input  NREQ*W  packed operand B; slice i belongs to requester i.
- gnt  output  NREQ  one-hot, one-cycle grant pulse.
- mul_strt  output  1  start pulse to the multiplier engine.
- mul_a  output  W  registered operand A to the engine.
- mul_b  output  W  registered operand B to the engine.
- mul_p  input  2W  engine product.
- mul_done  input  1  engine done level.
- rsp_valid  output  1  response valid.
- rsp_id  output  IDW  id of the requester that owns the response.
- rsp_p  output  2W  signed product.
- rsp_err  output  1  set when the watchdog expired.
- rsp_ready  input  1  consumer accepts the response.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - gnt, mul_strt, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, rsp_err and the wait counter all 0.
  - Last-grant pointer = NREQ-1, so requester 0 has highest priority first.
  - Reset taking effect mid-operation abandons the operation; no response is produced.
- IDLE:
  - If req != 0 at the edge, the winner is the first set bit searching from pointer+1 upward, modulo NREQ.
  - At that edge: latch a_in/b_in slice of the winner into mul_a/mul_b, latch winner into rsp_id, set pointer = winner, go to START.
  - If req == 0, stay in IDLE.
- START (exactly 1 cycle):
  - gnt[winner]=1 and mul_strt=1.
  - mul_a/mul_b are stable; they stay stable until the next grant.
  - Clear the wait counter, then go to WAIT.
  - The requester must drop req in this cycle; a req still high when the controller returns to IDLE is treated as a new request.
- WAIT:
  - mul_done=1 at the edge: capture rsp_p=mul_p, rsp_err=0, go to RESP.
  - Otherwise the counter increments.
  - Counter == TIMEOUT-1 without done: rsp_p=0, rsp_err=1, go to RESP.
  - If done and the timeout coincide, done wins.
  - mul_done is not looked at in IDLE or START, so a stale done level held by the engine from a previous operation is ignored.
- RESP:
  - rsp_valid=1 with rsp_id/rsp_p/rsp_err held stable.
  - rsp_ready=1 at the edge: rsp_valid drops and state goes to IDLE.
  - Backpressure is unbounded; no arbitration happens while in RESP.
- Only one operation is in flight at a time; the engine is never started while busy.
- Latency with an engine that raises done on the 5th edge after strt is sampled:
  - req sampled at edge e0.
  - gnt/mul_strt high in cycle e0..e1.
  - mul_done seen at e6.
  - rsp_valid high from e6.
  - Earliest next grant is the edge after rsp_ready is accepted, plus one cycle in IDLE.
- Fairness: a requester that keeps requesting is served at least once every NREQ operations.
- Products are passed through unmodified.
  - The controller does no arithmetic on data.
  - rsp_p is interpreted as two's complement, 2W bits.

Test Plan:
- Single request: req=0001, A=1011 (-5), B=1101 (-3), model engine done after 5 cycles -> gnt=0001 for one cycle, mul_strt one cycle, rsp_valid with rsp_id=0, rsp_p=0x0F (15), rsp_err=0, 6 edges after the req edge.
- Simultaneous requests: req=1111 held, requesters re-raise after each service, operands i*1 (e.g. requester 2: A=0011, B=1110) -> grant order 0,1,2,3,0; requester 2 gets rsp_p=0xFA (-6).
- Round-robin pointer: after serving 2, req=0101 -> requester 0 is granted before 2, because the search starts at 3 and wraps.
- Backpressure: rsp_ready=0 for 10 cycles with req=0010 pending -> rsp fields stay stable, no gnt and no mul_strt until ready, then requester 1 is granted.
- Watchdog: engine never raises done -> after 15 WAIT cycles rsp_valid=1, rsp_err=1, rsp_p=0x00; the next request still completes normally.
- Reset mid-WAIT: drop reset during WAIT -> all outputs 0 immediately; after release requester 0 has highest priority; no stale response appears.
